// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//
// Unified out-of-order issue queue feeding three execution units
// (ALU0, ALU1, LSU). Renamed instructions are inserted into the lowest free
// entry. Source readiness is tracked per entry and woken by result broadcasts.
// Each unit is offered the oldest eligible entry, where relative age comes
// from a DEPTH x DEPTH age matrix.
//
// Optional feature (compile-time macro):
//   ISSUE_SCHED_BYPASS_EN - a source woken by this cycle's broadcast counts as
//                           ready for selection in the same cycle
//                           (zero-cycle wakeup-to-issue). When the macro is
//                           undefined, a woken entry becomes eligible one
//                           cycle after the broadcast.
//
// Parameters:
//   DEPTH  - number of queue entries (power of two, 4..16)
//   PREG_W - physical register tag width
//   ROB_W  - ROB index width
//
// Ports:
//   clk, rstn          - clock (rising edge), asynchronous active-low reset
//   disp_valid/ready   - dispatch handshake
//   disp_sr1_p/sr2_p   - source physical tags
//   disp_dr_p          - destination physical tag
//   disp_s1/s2_ready   - source operand already available at dispatch
//   disp_aluOp         - ALU operation
//   disp_imm           - immediate
//   disp_rob           - ROB index
//   disp_FU            - target unit (0 ALU0, 1 ALU1, 2 LSU, 3 -> ALU0)
//   wb_valid, wb_preg  - result broadcast (wakeup)
//   iss_valid[2:0]     - per-unit issue request (bit index = unit)
//   iss_ready[2:0]     - per-unit accept
//   iss_payload        - per-unit {sr1, sr2, dr, aluOp, imm, rob}, unit 0 in LSBs
//   flush              - squash every queued entry
//   occupancy          - number of valid entries
// -----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   disp_valid,
    output logic                                   disp_ready,
    input  logic [PREG_W-1:0]                      disp_sr1_p,
    input  logic [PREG_W-1:0]                      disp_sr2_p,
    input  logic [PREG_W-1:0]                      disp_dr_p,
    input  logic                                   disp_s1_ready,
    input  logic                                   disp_s2_ready,
    input  logic [1:0]                             disp_aluOp,
    input  logic [31:0]                            disp_imm,
    input  logic [ROB_W-1:0]                       disp_rob,
    input  logic [1:0]                             disp_FU,
    input  logic                                   wb_valid,
    input  logic [PREG_W-1:0]                      wb_preg,
    output logic [2:0]                             iss_valid,
    input  logic [2:0]                             iss_ready,
    output logic [3*(3*PREG_W+2+32+ROB_W)-1:0]     iss_payload,
    input  logic                                   flush,
    output logic [$clog2(DEPTH):0]                 occupancy
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int OCC_W  = IDX_W + 1;
    localparam int PAY_W  = 3*PREG_W + 2 + 32 + ROB_W;
    localparam int NUM_FU = 3;

    // Entry state: control (reset) and payload (no reset)
    logic [DEPTH-1:0]  entValid;
    logic [DEPTH-1:0]  entS1Rdy;
    logic [DEPTH-1:0]  entS2Rdy;
    logic [1:0]        entFu    [DEPTH];
    logic [PREG_W-1:0] entSr1   [DEPTH];
    logic [PREG_W-1:0] entSr2   [DEPTH];
    logic [PREG_W-1:0] entDr    [DEPTH];
    logic [1:0]        entAluOp [DEPTH];
    logic [31:0]       entImm   [DEPTH];
    logic [ROB_W-1:0]  entRob   [DEPTH];

    // ageMat[i][j] set means entry i was dispatched before entry j
    logic [DEPTH-1:0]  ageMat   [DEPTH];
    // olderOf[i][j] set means entry j is older than entry i (column view)
    logic [DEPTH-1:0]  olderOf  [DEPTH];

    logic [OCC_W-1:0]  occCount;

    logic [DEPTH-1:0]  wake1;
    logic [DEPTH-1:0]  wake2;
    logic [DEPTH-1:0]  effRdy1;
    logic [DEPTH-1:0]  effRdy2;
    logic [DEPTH-1:0]  elig     [NUM_FU];
    logic [DEPTH-1:0]  sel      [NUM_FU];
    logic [PAY_W-1:0]  payMux   [NUM_FU];
    logic [DEPTH-1:0]  issueMask;
    logic [2:0]        fire;
    logic [1:0]        issueCnt;

    logic [IDX_W-1:0]  insIdx;
    logic              doInsert;
    logic [1:0]        fuMap;
    logic              s1In;
    logic              s2In;

    // ---------------- wakeup and eligibility ----------------
    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = wb_valid && (entSr1[i] == wb_preg);
            wake2[i] = wb_valid && (entSr2[i] == wb_preg);
        end
    end

`ifdef ISSUE_SCHED_BYPASS_EN
    assign effRdy1 = entS1Rdy | wake1;
    assign effRdy2 = entS2Rdy | wake2;
`else
    assign effRdy1 = entS1Rdy;
    assign effRdy2 = entS2Rdy;
`endif

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            olderOf[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                olderOf[i][j] = ageMat[j][i];
            end
        end
    end

    // An entry wins its unit when it is eligible and no other eligible
    // entry for that unit is older. The age matrix is a total order over
    // valid entries, so the result is one-hot.
    always_comb begin
        for (int u = 0; u < NUM_FU; u++) begin
            elig[u] = '0;
            sel[u]  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                elig[u][i] = entValid[i] & effRdy1[i] & effRdy2[i] & (entFu[i] == 2'(u));
            end
            for (int i = 0; i < DEPTH; i++) begin
                sel[u][i] = elig[u][i] & ~(|(elig[u] & olderOf[i]));
            end
        end
    end

    always_comb begin
        iss_valid   = '0;
        iss_payload = '0;
        for (int u = 0; u < NUM_FU; u++) begin
            iss_valid[u] = |elig[u];
            payMux[u]    = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (sel[u][i]) begin
                    payMux[u] = payMux[u] |
                                {entSr1[i], entSr2[i], entDr[i], entAluOp[i], entImm[i], entRob[i]};
                end
            end
            iss_payload[u*PAY_W +: PAY_W] = payMux[u];
        end
    end

    assign fire     = iss_valid & iss_ready;
    assign issueCnt = 2'(fire[0]) + 2'(fire[1]) + 2'(fire[2]);

    always_comb begin
        issueMask = '0;
        for (int u = 0; u < NUM_FU; u++) begin
            if (iss_ready[u]) begin
                issueMask = issueMask | sel[u];
            end
        end
    end

    // ---------------- insertion ----------------
    // Free slots come from registered valid bits only, so a slot vacated by
    // an issue this cycle is not reused until the next cycle.
    always_comb begin
        insIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!entValid[i]) begin
                insIdx = IDX_W'(i);
            end
        end
    end

    assign disp_ready = (occCount < OCC_W'(DEPTH));
    assign doInsert   = disp_valid && disp_ready && !flush;
    assign fuMap      = (disp_FU == 2'd3) ? 2'd0 : disp_FU;

    // Tag 0 is the hardwired-ready register; a same-cycle broadcast of the
    // source tag is also captured as ready.
    assign s1In = disp_s1_ready || (disp_sr1_p == '0) ||
                  (wb_valid && (disp_sr1_p == wb_preg));
    assign s2In = disp_s2_ready || (disp_sr2_p == '0) ||
                  (wb_valid && (disp_sr2_p == wb_preg));

    assign occupancy = occCount;

    // ---------------- state update ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            entValid <= '0;
            entS1Rdy <= '0;
            entS2Rdy <= '0;
            occCount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entFu[i]  <= 2'd0;
                ageMat[i] <= '0;
            end
        end else if (flush) begin
            entValid <= '0;
            occCount <= '0;
        end else begin
            entS1Rdy <= entS1Rdy | (wake1 & entValid);
            entS2Rdy <= entS2Rdy | (wake2 & entValid);
            entValid <= entValid & ~issueMask;
            if (doInsert) begin
                entValid[insIdx] <= 1'b1;
                entS1Rdy[insIdx] <= s1In;
                entS2Rdy[insIdx] <= s2In;
                entFu[insIdx]    <= fuMap;
                // New entry is younger than every currently valid entry.
                for (int j = 0; j < DEPTH; j++) begin
                    ageMat[insIdx][j] <= 1'b0;
                    ageMat[j][insIdx] <= entValid[j];
                end
            end
            occCount <= occCount + OCC_W'(doInsert) - OCC_W'(issueCnt);
        end
    end

    always_ff @(posedge clk) begin
        if (doInsert) begin
            entSr1[insIdx]   <= disp_sr1_p;
            entSr2[insIdx]   <= disp_sr2_p;
            entDr[insIdx]    <= disp_dr_p;
            entAluOp[insIdx] <= disp_aluOp;
            entImm[insIdx]   <= disp_imm;
            entRob[insIdx]   <= disp_rob;
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

    localparam int DEPTH  = 8;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
    localparam int PAY_W  = 3*PREG_W + 2 + 32 + ROB_W;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [PREG_W-1:0]    disp_sr1_p, disp_sr2_p, disp_dr_p;
    logic                 disp_s1_ready, disp_s2_ready;
    logic [1:0]           disp_aluOp;
    logic [31:0]          disp_imm;
    logic [ROB_W-1:0]     disp_rob;
    logic [1:0]           disp_FU;
    logic                 wb_valid;
    logic [PREG_W-1:0]    wb_preg;
    logic [2:0]           iss_valid;
    logic [2:0]           iss_ready;
    logic [3*PAY_W-1:0]   iss_payload;
    logic                 flush;
    logic [$clog2(DEPTH):0] occupancy;

    issue_scheduler #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rstn(rstn),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_sr1_p(disp_sr1_p), .disp_sr2_p(disp_sr2_p), .disp_dr_p(disp_dr_p),
        .disp_s1_ready(disp_s1_ready), .disp_s2_ready(disp_s2_ready),
        .disp_aluOp(disp_aluOp), .disp_imm(disp_imm), .disp_rob(disp_rob),
        .disp_FU(disp_FU), .wb_valid(wb_valid), .wb_preg(wb_preg),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // Expected issue payloads per unit, in expected issue order.
    logic [PAY_W-1:0] q0[$];
    logic [PAY_W-1:0] q1[$];
    logic [PAY_W-1:0] q2[$];

    function automatic logic [PAY_W-1:0] mkPay(input logic [PREG_W-1:0] s1, input logic [PREG_W-1:0] s2,
                                               input logic [PREG_W-1:0] dr, input logic [1:0] op,
                                               input logic [31:0] imm, input logic [ROB_W-1:0] rob);
        return {s1, s2, dr, op, imm, rob};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic pushExp(input int unit, input logic [PAY_W-1:0] p);
        case (unit)
            0: q0.push_back(p);
            1: q1.push_back(p);
            default: q2.push_back(p);
        endcase
    endtask

    // Compare every handshake about to occur at the coming edge.
    task automatic monitor();
        logic [PAY_W-1:0] got;
        logic [PAY_W-1:0] exp;
        int sz;
        for (int u = 0; u < 3; u++) begin
            if (iss_valid[u] && iss_ready[u] && !flush) begin
                got = iss_payload[u*PAY_W +: PAY_W];
                case (u)
                    0: sz = q0.size();
                    1: sz = q1.size();
                    default: sz = q2.size();
                endcase
                chk($sformatf("sb_pending_u%0d", u), 64'(sz != 0), 64'(1));
                if (sz != 0) begin
                    case (u)
                        0: exp = q0.pop_front();
                        1: exp = q1.pop_front();
                        default: exp = q2.pop_front();
                    endcase
                    chk($sformatf("issue_payload_u%0d", u), 64'(got), 64'(exp));
                end
            end
        end
    endtask

    // Called at negedge+1: settle, check handshakes, pass the rising edge.
    task automatic cycle();
        #2;
        monitor();
        @(negedge clk);
        #1;
    endtask

    task automatic setDisp(input logic [1:0] fu, input logic [PREG_W-1:0] s1, input logic r1,
                           input logic [PREG_W-1:0] s2, input logic r2, input logic [PREG_W-1:0] dr,
                           input logic [1:0] op, input logic [31:0] imm, input logic [ROB_W-1:0] rob,
                           input int expUnit);
        disp_valid    = 1'b1;
        disp_FU       = fu;
        disp_sr1_p    = s1;
        disp_s1_ready = r1;
        disp_sr2_p    = s2;
        disp_s2_ready = r2;
        disp_dr_p     = dr;
        disp_aluOp    = op;
        disp_imm      = imm;
        disp_rob      = rob;
        if (expUnit >= 0) pushExp(expUnit, mkPay(s1, s2, dr, op, imm, rob));
    endtask

    initial begin
        rstn = 1'b0; disp_valid = 1'b0; disp_sr1_p = '0; disp_sr2_p = '0; disp_dr_p = '0;
        disp_s1_ready = 1'b0; disp_s2_ready = 1'b0; disp_aluOp = '0; disp_imm = '0;
        disp_rob = '0; disp_FU = '0; wb_valid = 1'b0; wb_preg = '0; iss_ready = '0; flush = 1'b0;

        // Reset state
        #3;
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_iss_valid", 64'(iss_valid), 64'(0));
        chk("rst_disp_ready", 64'(disp_ready), 64'(1));
        @(negedge clk); #1;
        rstn = 1'b1;
        cycle();

        // Single ALU0 op, both sources ready
        iss_ready = 3'b111;
        setDisp(2'd0, 6'd3, 1'b1, 6'd4, 1'b1, 6'd7, 2'd1, 32'hDEAD_BEEF, 6'd5, 0);
        cycle();
        disp_valid = 1'b0;
        chk("single_occ_1", 64'(occupancy), 64'(1));
        chk("single_iss_valid", 64'(iss_valid), 64'(3'b001));
        cycle();
        chk("single_occ_0", 64'(occupancy), 64'(0));
        chk("single_iss_idle", 64'(iss_valid), 64'(0));

        // Not-ready older entry is bypassed by a ready younger one, then woken
        setDisp(2'd0, 6'd12, 1'b0, 6'd13, 1'b1, 6'd14, 2'd2, 32'h0000_1111, 6'd1, -1);
        cycle();
        chk("wait_not_ready", 64'(iss_valid), 64'(0));
        setDisp(2'd0, 6'd15, 1'b1, 6'd16, 1'b1, 6'd17, 2'd3, 32'h0000_2222, 6'd2, 0);
        pushExp(0, mkPay(6'd12, 6'd13, 6'd14, 2'd2, 32'h0000_1111, 6'd1));
        cycle();
        disp_valid = 1'b0;
        chk("young_ready_valid", 64'(iss_valid), 64'(3'b001));
        cycle();
        chk("after_young_occ", 64'(occupancy), 64'(1));
        chk("after_young_idle", 64'(iss_valid), 64'(0));
        wb_valid = 1'b1; wb_preg = 6'd33;
        cycle();
        chk("nomatch_wake_idle", 64'(iss_valid), 64'(0));
        chk("nomatch_wake_occ", 64'(occupancy), 64'(1));
        wb_preg = 6'd12;
        cycle();
        wb_valid = 1'b0;
`ifdef ISSUE_SCHED_BYPASS_EN
        chk("wake_bypass_occ", 64'(occupancy), 64'(0));
`else
        chk("wake_occ", 64'(occupancy), 64'(1));
        chk("wake_iss_valid", 64'(iss_valid), 64'(3'b001));
`endif
        cycle();
        chk("wake_drained", 64'(occupancy), 64'(0));

        // Same-cycle broadcast captured at dispatch
        iss_ready = 3'b000;
        setDisp(2'd0, 6'd20, 1'b0, 6'd21, 1'b1, 6'd22, 2'd0, 32'h0000_3333, 6'd9, 0);
        wb_valid = 1'b1; wb_preg = 6'd20;
        cycle();
        disp_valid = 1'b0; wb_valid = 1'b0;
        chk("disp_wb_capture", 64'(iss_valid), 64'(3'b001));
        iss_ready = 3'b001;
        cycle();
        chk("disp_wb_drained", 64'(occupancy), 64'(0));

        // Fill the queue, refuse overflow, age order beats index order
        iss_ready = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            setDisp(2'd1, 6'(30 + i), 1'b1, 6'd1, 1'b1, 6'(40 + i), 2'd1, 32'(i * 7), 6'(10 + i), 1);
            cycle();
        end
        chk("full_occ", 64'(occupancy), 64'(DEPTH));
        chk("full_disp_ready", 64'(disp_ready), 64'(0));
        chk("full_iss_valid", 64'(iss_valid), 64'(3'b010));
        setDisp(2'd1, 6'd50, 1'b1, 6'd51, 1'b1, 6'd52, 2'd0, 32'h0000_9999, 6'd30, -1);
        cycle();
        disp_valid = 1'b0;
        chk("overflow_ignored", 64'(occupancy), 64'(DEPTH));
        iss_ready = 3'b010;
        cycle();
        chk("one_out_occ", 64'(occupancy), 64'(DEPTH - 1));
        chk("one_out_ready", 64'(disp_ready), 64'(1));
        iss_ready = 3'b000;
        setDisp(2'd1, 6'd60, 1'b1, 6'd61, 1'b1, 6'd62, 2'd2, 32'hABCD_0000, 6'd18, 1);
        cycle();
        disp_valid = 1'b0;
        chk("refill_occ", 64'(occupancy), 64'(DEPTH));
        iss_ready = 3'b010;
        for (int i = 0; i < DEPTH; i++) cycle();
        chk("drain_occ", 64'(occupancy), 64'(0));
        chk("drain_disp_ready", 64'(disp_ready), 64'(1));

        // One entry per unit, tag 0 counts as ready, triple issue
        iss_ready = 3'b000;
        setDisp(2'd0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd23, 2'd1, 32'h0000_0020, 6'd20, 0);
        cycle();
        setDisp(2'd1, 6'd24, 1'b1, 6'd25, 1'b1, 6'd26, 2'd2, 32'h0000_0021, 6'd21, 1);
        cycle();
        setDisp(2'd2, 6'd27, 1'b1, 6'd0, 1'b0, 6'd28, 2'd3, 32'h0000_0022, 6'd22, 2);
        cycle();
        disp_valid = 1'b0;
        chk("three_occ", 64'(occupancy), 64'(3));
        chk("three_iss_valid", 64'(iss_valid), 64'(3'b111));
        iss_ready = 3'b111;
        cycle();
        chk("three_issued_occ", 64'(occupancy), 64'(0));

        // Reserved FU code routes to ALU0
        iss_ready = 3'b000;
        setDisp(2'd3, 6'd5, 1'b1, 6'd6, 1'b1, 6'd8, 2'd0, 32'h0000_0023, 6'd23, 0);
        cycle();
        disp_valid = 1'b0;
        chk("fu3_alu0", 64'(iss_valid), 64'(3'b001));
        iss_ready = 3'b001;
        cycle();
        chk("fu3_drained", 64'(occupancy), 64'(0));

        // Flush with a dispatch and ready units in the same cycle
        iss_ready = 3'b000;
        for (int i = 0; i < 5; i++) begin
            setDisp(2'd0, 6'd2, 1'b1, 6'd3, 1'b1, 6'd4, 2'd0, 32'(i), 6'(40 + i), -1);
            cycle();
        end
        chk("preflush_occ", 64'(occupancy), 64'(5));
        setDisp(2'd0, 6'd2, 1'b1, 6'd3, 1'b1, 6'd4, 2'd0, 32'h0000_0045, 6'd45, -1);
        flush = 1'b1; iss_ready = 3'b111;
        cycle();
        flush = 1'b0; disp_valid = 1'b0;
        chk("flush_occ", 64'(occupancy), 64'(0));
        chk("flush_iss_valid", 64'(iss_valid), 64'(0));
        cycle();
        chk("flush_disp_dropped", 64'(occupancy), 64'(0));

        // Reset mid-operation discards entries
        iss_ready = 3'b000;
        setDisp(2'd0, 6'd2, 1'b1, 6'd3, 1'b1, 6'd4, 2'd0, 32'h0000_0050, 6'd50, -1);
        cycle();
        setDisp(2'd1, 6'd2, 1'b1, 6'd3, 1'b1, 6'd4, 2'd0, 32'h0000_0051, 6'd51, -1);
        cycle();
        disp_valid = 1'b0;
        chk("pre_rst_occ", 64'(occupancy), 64'(2));
        rstn = 1'b0;
        #1;
        chk("midrst_occ", 64'(occupancy), 64'(0));
        chk("midrst_iss_valid", 64'(iss_valid), 64'(0));
        chk("midrst_disp_ready", 64'(disp_ready), 64'(1));
        @(negedge clk); #1;
        rstn = 1'b1;
        iss_ready = 3'b111;
        cycle();
        chk("post_rst_idle", 64'(iss_valid), 64'(0));
        chk("post_rst_occ", 64'(occupancy), 64'(0));

        chk("sb_empty_u0", 64'(q0.size()), 64'(0));
        chk("sb_empty_u1", 64'(q1.size()), 64'(0));
        chk("sb_empty_u2", 64'(q2.size()), 64'(0));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
